// File: rtl/fmap_stream_reader_pkg.sv
// fmap_stream_reader_pkg: shared state encoding, element type and default map geometry.
package fmap_stream_reader_pkg;
  localparam int CHANNEL_SIZE = 195;
  localparam int OC = 15;
  localparam int ADDR_LEN = 7;
  localparam int CH_W = 4;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
  typedef logic signed [7:0] elem_t;
endpackage

// File: rtl/fmap_stream_reader_stream_fifo2.sv
// stream_fifo2: 2-entry FIFO holding element, channel tag and last flag; head is always visible.
module stream_fifo2
  import fmap_stream_reader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  elem_t           push_data_i,
  input  logic [CH_W-1:0] push_ch_i,
  input  logic            push_last_i,
  input  logic            pop_i,
  output elem_t           head_data_o,
  output logic [CH_W-1:0] head_ch_o,
  output logic            head_last_o,
  output logic [1:0]      count_o
);
  elem_t           data_q [2];
  logic [CH_W-1:0] ch_q [2];
  logic [1:0]      last_q;
  logic            wr_q, rd_q;
  logic [1:0]      cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      ch_q[0]   <= '0;
      ch_q[1]   <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= push_data_i;
        ch_q[wr_q]   <= push_ch_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end
  // Pushing into the other slot never disturbs the head, so a stalled output stays stable.
  assign head_data_o = data_q[rd_q];
  assign head_ch_o   = ch_q[rd_q];
  assign head_last_o = last_q[rd_q];
  assign count_o     = cnt_q;
endmodule

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: walks the pooled layer-2 map channel-major and streams each byte on valid/ready.
// Optional ARGMAX_TRACK_EN adds running max_val/max_ch over the handshaken stream.
module fmap_stream_reader
  import fmap_stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_load,
  output logic [CH_W-1:0]   mem_ch,
  output logic [ADDR_LEN:0] mem_addr,
  input  elem_t             mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output elem_t             out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              busy,
`ifdef ARGMAX_TRACK_EN
  output elem_t             max_val,
  output logic [CH_W-1:0]   max_ch,
`endif
  output logic              done
);
  localparam logic [ADDR_LEN:0] A_LAST = CHANNEL_SIZE[ADDR_LEN:0];
  localparam logic [CH_W-1:0]   C_LAST = OC[CH_W-1:0];
  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_LEN:0] addr_q, addr_d;
  logic              infl_q, infl_last_q, done_q;
  logic [CH_W-1:0]   infl_ch_q;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              pop, last_rd, accept;
  assign pop     = out_valid && out_ready;
  assign last_rd = ch_q == C_LAST && addr_q == A_LAST;
  assign accept  = state_q == IDLE && start;
  // Credit counts the slot a same-cycle pop frees, which keeps one element per cycle at full ready.
  assign occ      = 3'(cnt) + 3'(infl_q) - 3'(pop);
  assign mem_load = state_q == READ && occ < 3'd2;
  assign mem_ch   = ch_q;
  assign mem_addr = addr_q;
  assign out_valid = cnt != 2'd0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        ch_d    = '0;
        addr_d  = '0;
      end
      READ: if (mem_load) begin
        addr_d  = addr_q == A_LAST ? '0 : addr_q + 1'b1;
        ch_d    = addr_q == A_LAST ? ch_q + 1'b1 : ch_q;
        state_d = last_rd ? DRAIN : READ;
      end
      DRAIN: state_d = pop && out_last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_ch_q   <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      infl_q      <= mem_load;
      infl_ch_q   <= ch_q;
      infl_last_q <= mem_load && last_rd;
      done_q      <= state_q == DRAIN && pop && out_last;
    end
  end
  stream_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (infl_q),
    .push_data_i (mem_data),
    .push_ch_i   (infl_ch_q),
    .push_last_i (infl_last_q),
    .pop_i       (pop),
    .head_data_o (out_data),
    .head_ch_o   (out_ch),
    .head_last_o (out_last),
    .count_o     (cnt)
  );
`ifdef ARGMAX_TRACK_EN
  elem_t           max_val_q;
  logic [CH_W-1:0] max_ch_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val_q <= '0;
      max_ch_q  <= '0;
    end else if (accept) begin
      max_val_q <= -8'sd128;
      max_ch_q  <= '0;
    end else if (pop && out_data > max_val_q) begin
      max_val_q <= out_data;
      max_ch_q  <= out_ch;
    end
  end
  assign max_val = max_val_q;
  assign max_ch  = max_ch_q;
`endif
endmodule
